// File: rtl/charram_access_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : charram_access_sequencer_if
// Brief    : Slot request, CPU port, video port and DRAM pin bundle for the
//            character RAM access sequencer.
// Revision : 1.0
// ============================================================================
interface charram_access_sequencer_if;
    logic        i_SLOT_STRB;
    logic [13:0] i_VID_ADDR;
    logic        i_CPU_REQ;
    logic        i_CPU_WR;
    logic [13:0] i_CPU_ADDR;
    logic [3:0]  i_CPU_DIN;
    logic [3:0]  i_DRAM_DOUT;

    logic        o_CPU_DTACK_n;
    logic [3:0]  o_CPU_DOUT;
    logic        o_VID_VALID;
    logic [3:0]  o_VID_DATA;
    logic        o_RAS_n;
    logic        o_CAS_n;
    logic        o_WR_n;
    logic        o_RD_n;
    logic [7:0]  o_ADDR;
    logic [3:0]  o_DIN;

    // Requester / DRAM side
    modport master (
        output i_SLOT_STRB, i_VID_ADDR, i_CPU_REQ, i_CPU_WR, i_CPU_ADDR,
               i_CPU_DIN, i_DRAM_DOUT,
        input  o_CPU_DTACK_n, o_CPU_DOUT, o_VID_VALID, o_VID_DATA,
               o_RAS_n, o_CAS_n, o_WR_n, o_RD_n, o_ADDR, o_DIN
    );

    // Sequencer side
    modport slave (
        input  i_SLOT_STRB, i_VID_ADDR, i_CPU_REQ, i_CPU_WR, i_CPU_ADDR,
               i_CPU_DIN, i_DRAM_DOUT,
        output o_CPU_DTACK_n, o_CPU_DOUT, o_VID_VALID, o_VID_DATA,
               o_RAS_n, o_CAS_n, o_WR_n, o_RD_n, o_ADDR, o_DIN
    );
endinterface
`default_nettype wire

// File: rtl/charram_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : charram_access_sequencer
// Brief    : Time-slotted DRAM sequencer sharing a 16Kx4 character RAM between
//            video fetches and a CPU that owns one slot in CPU_SLOT_EVERY.
// Revision : 1.0
// ============================================================================
module charram_access_sequencer #(
    parameter int CPU_SLOT_EVERY = 2
) (
    input  wire logic                   i_MCLK,
    input  wire logic                   i_RST_n,
    charram_access_sequencer_if.slave   bus
);

    localparam int SLOT_W = (CPU_SLOT_EVERY > 1) ? $clog2(CPU_SLOT_EVERY) : 1;
    localparam logic [SLOT_W-1:0] c_LAST_SLOT = SLOT_W'(CPU_SLOT_EVERY - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROW  = 3'd1,
        COL  = 3'd2,
        ACC  = 3'd3,
        CAP  = 3'd4,
        PRE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [13:0]        addr_q, addr_d;
    logic               wr_q, wr_d;
    logic               cpu_q, cpu_d;
    logic [3:0]         wdata_q, wdata_d;

    logic               ras_n_q, ras_n_d;
    logic               cas_n_q, cas_n_d;
    logic               wr_n_q, wr_n_d;
    logic               rd_n_q, rd_n_d;
    logic [7:0]         dram_addr_q, dram_addr_d;
    logic [3:0]         dram_din_q, dram_din_d;
    logic               cpu_dtack_n_q, cpu_dtack_n_d;
    logic [3:0]         cpu_dout_q, cpu_dout_d;
    logic               vid_valid_q, vid_valid_d;
    logic [3:0]         vid_data_q, vid_data_d;

    logic               w_accept;
    logic               w_cpu_slot;
    logic [13:0]        w_sel_addr;

    assign w_accept   = (state_q == IDLE) && bus.i_SLOT_STRB;
    // An outstanding DTACK blocks a new CPU access until the CPU drops REQ.
    assign w_cpu_slot = (slot_q == c_LAST_SLOT) && bus.i_CPU_REQ && cpu_dtack_n_q;
    assign w_sel_addr = w_cpu_slot ? bus.i_CPU_ADDR : bus.i_VID_ADDR;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        cpu_d         = cpu_q;
        wdata_d       = wdata_q;
        ras_n_d       = 1'b1;
        cas_n_d       = 1'b1;
        wr_n_d        = 1'b1;
        rd_n_d        = 1'b1;
        dram_addr_d   = dram_addr_q;
        dram_din_d    = dram_din_q;
        cpu_dtack_n_d = cpu_dtack_n_q;
        cpu_dout_d    = cpu_dout_q;
        vid_valid_d   = 1'b0;
        vid_data_d    = vid_data_q;

        if (!cpu_dtack_n_q && !bus.i_CPU_REQ) begin
            cpu_dtack_n_d = 1'b1;
        end

        // Outputs are computed for the state being entered, so every pin is a flop.
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d     = ROW;
                    slot_d      = (slot_q == c_LAST_SLOT) ? '0 : slot_q + 1'b1;
                    cpu_d       = w_cpu_slot;
                    wr_d        = w_cpu_slot && bus.i_CPU_WR;
                    addr_d      = w_sel_addr;
                    wdata_d     = bus.i_CPU_DIN;
                    ras_n_d     = 1'b0;
                    dram_addr_d = w_sel_addr[7:0];
                end
            end
            ROW: begin
                state_d     = COL;
                ras_n_d     = 1'b0;
                cas_n_d     = 1'b0;
                dram_addr_d = {1'b0, addr_q[13:8], 1'b0};
            end
            COL: begin
                state_d = ACC;
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
                rd_n_d  = wr_q;
                wr_n_d  = !wr_q;
                if (wr_q) begin
                    dram_din_d = wdata_q;
                end
            end
            ACC: begin
                state_d = CAP;
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
            end
            CAP: begin
                state_d = PRE;
                if (cpu_q) begin
                    cpu_dtack_n_d = 1'b0;
                    if (!wr_q) begin
                        cpu_dout_d = bus.i_DRAM_DOUT;
                    end
                end else begin
                    vid_valid_d = 1'b1;
                    vid_data_d  = bus.i_DRAM_DOUT;
                end
            end
            PRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            addr_q        <= '0;
            wr_q          <= 1'b0;
            cpu_q         <= 1'b0;
            wdata_q       <= '0;
            ras_n_q       <= 1'b1;
            cas_n_q       <= 1'b1;
            wr_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            dram_addr_q   <= '0;
            dram_din_q    <= '0;
            cpu_dtack_n_q <= 1'b1;
            cpu_dout_q    <= '0;
            vid_valid_q   <= 1'b0;
            vid_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            addr_q        <= addr_d;
            wr_q          <= wr_d;
            cpu_q         <= cpu_d;
            wdata_q       <= wdata_d;
            ras_n_q       <= ras_n_d;
            cas_n_q       <= cas_n_d;
            wr_n_q        <= wr_n_d;
            rd_n_q        <= rd_n_d;
            dram_addr_q   <= dram_addr_d;
            dram_din_q    <= dram_din_d;
            cpu_dtack_n_q <= cpu_dtack_n_d;
            cpu_dout_q    <= cpu_dout_d;
            vid_valid_q   <= vid_valid_d;
            vid_data_q    <= vid_data_d;
        end
    end

    assign bus.o_RAS_n       = ras_n_q;
    assign bus.o_CAS_n       = cas_n_q;
    assign bus.o_WR_n        = wr_n_q;
    assign bus.o_RD_n        = rd_n_q;
    assign bus.o_ADDR        = dram_addr_q;
    assign bus.o_DIN         = dram_din_q;
    assign bus.o_CPU_DTACK_n = cpu_dtack_n_q;
    assign bus.o_CPU_DOUT    = cpu_dout_q;
    assign bus.o_VID_VALID   = vid_valid_q;
    assign bus.o_VID_DATA    = vid_data_q;

endmodule
`default_nettype wire
